decode_rr_arbiter: RTL and testbench

- 16-way round-robin arbiter that shares a 4-to-16 active-low select decoder among 16 requesters.
- Produces the decoder index (sel_idx) and the decoder enables (sel_e1 high and sel_e2 low means enabled).
- Also produces a registered one-cold grant vector that mirrors the decoder output, so consumers do not need to re-decode.
- Guarantees break-before-make between grants and enforces a maximum hold time per grant.

---
 rtl/decode_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_decode_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_rr_arbiter.sv
// rtl/decode_rr_arbiter.sv - 16-way round-robin arbiter driving a shared 4-to-16 active-low select decoder
// Optional macro DECODE_ARB_LOCK_EN adds a lock input that suspends the hold-time limit.
module decode_rr_arbiter #(
    parameter int HOLD_MAX   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
`ifdef DECODE_ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic [3:0]  sel_idx,
    output logic        sel_e1,
    output logic        sel_e2,
    output logic [15:0] gnt_n,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  sel_idx_q, sel_idx_d;
    logic        sel_e1_q, sel_e1_d;
    logic        sel_e2_q, sel_e2_d;
    logic [15:0] gnt_n_q, gnt_n_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;

    logic        lock_eff;
    logic        found;
    logic [3:0]  winner;
    logic        cur_req;
    logic        hold_hit;
    logic        grant_exit;

`ifdef DECODE_ARB_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    // Search starts just past the last served line so it ends up lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            if (!found && req[ptr_q + 4'(k)]) begin
                found  = 1'b1;
                winner = ptr_q + 4'(k);
            end
        end
    end

    assign cur_req    = req[sel_idx_q];
    assign hold_hit   = (HOLD_MAX != 0) && (hold_cnt_q == 8'(HOLD_MAX)) && !lock_eff;
    assign grant_exit = !cur_req || hold_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_idx_q  <= 4'd0;
            sel_e1_q   <= 1'b0;
            sel_e2_q   <= 1'b1;
            gnt_n_q    <= 16'hFFFF;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= 4'd15;
            hold_cnt_q <= 8'd0;
            gap_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            sel_idx_q  <= sel_idx_d;
            sel_e1_q   <= sel_e1_d;
            sel_e2_q   <= sel_e2_d;
            gnt_n_q    <= gnt_n_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (found) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (grant_exit) state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs default to the inactive decoder state; only IDLE->GRANT and a held GRANT drive them active.
    always_comb begin
        sel_idx_d  = sel_idx_q;
        sel_e1_d   = 1'b0;
        sel_e2_d   = 1'b1;
        gnt_n_d    = 16'hFFFF;
        busy_d     = 1'b0;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_idx_d  = winner;
                    sel_e1_d   = 1'b1;
                    sel_e2_d   = 1'b0;
                    gnt_n_d    = ~(16'h0001 << winner);
                    busy_d     = 1'b1;
                    hold_cnt_d = 8'd1;
                end
            end
            ST_GRANT: begin
                if (grant_exit) begin
                    ptr_d     = sel_idx_q;
                    timeout_d = cur_req;
                    gap_cnt_d = 4'd1;
                end else begin
                    sel_e1_d = 1'b1;
                    sel_e2_d = 1'b0;
                    gnt_n_d  = gnt_n_q;
                    busy_d   = 1'b1;
                    if (!lock_eff && hold_cnt_q != 8'd255) hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != 4'(GAP_CYCLES)) gap_cnt_d = gap_cnt_q + 4'd1;
            end
            default: ;
        endcase
    end

    assign sel_idx = sel_idx_q;
    assign sel_e1  = sel_e1_q;
    assign sel_e2  = sel_e2_q;
    assign gnt_n   = gnt_n_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_decode_rr_arbiter.sv
// tb/tb_decode_rr_arbiter.sv - bench for decode_rr_arbiter, three parameter sets against a behavioural model
module tb_decode_rr_arbiter;

    localparam int HM0 = 16, GC0 = 1;
    localparam int HM1 = 4,  GC1 = 1;
    localparam int HM2 = 0,  GC2 = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = 16'h0;
    logic        lock_v = 1'b0;

    logic [3:0]  sel_idx [3];
    logic        sel_e1  [3];
    logic        sel_e2  [3];
    logic [15:0] gnt_n   [3];
    logic        busy    [3];
    logic        timeout [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_rr_arbiter #(.HOLD_MAX(HM0), .GAP_CYCLES(GC0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef DECODE_ARB_LOCK_EN
        .lock(lock_v),
`endif
        .sel_idx(sel_idx[0]), .sel_e1(sel_e1[0]), .sel_e2(sel_e2[0]),
        .gnt_n(gnt_n[0]), .busy(busy[0]), .timeout(timeout[0]));

    decode_rr_arbiter #(.HOLD_MAX(HM1), .GAP_CYCLES(GC1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef DECODE_ARB_LOCK_EN
        .lock(lock_v),
`endif
        .sel_idx(sel_idx[1]), .sel_e1(sel_e1[1]), .sel_e2(sel_e2[1]),
        .gnt_n(gnt_n[1]), .busy(busy[1]), .timeout(timeout[1]));

    decode_rr_arbiter #(.HOLD_MAX(HM2), .GAP_CYCLES(GC2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef DECODE_ARB_LOCK_EN
        .lock(lock_v),
`endif
        .sel_idx(sel_idx[2]), .sel_e1(sel_e1[2]), .sel_e2(sel_e2[2]),
        .gnt_n(gnt_n[2]), .busy(busy[2]), .timeout(timeout[2]));

    // Model: who owns the decoder, for how long, and how many dead cycles remain before arbitrating.
    int hm [3];
    int gc [3];
    int owner [3];
    int held  [3];
    int waitc [3];
    int last  [3];
    int sidx  [3];
    bit tmo   [3];

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            owner[i] = -1; held[i] = 0; waitc[i] = 0;
            last[i] = 15; sidx[i] = 0; tmo[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [15:0] r, input logic lk);
        for (int i = 0; i < 3; i++) begin
            tmo[i] = 1'b0;
            if (owner[i] >= 0) begin
                if (!r[owner[i]]) begin
                    last[i] = owner[i]; owner[i] = -1; waitc[i] = gc[i];
                end else if (hm[i] != 0 && !lk && held[i] == hm[i]) begin
                    last[i] = owner[i]; owner[i] = -1; waitc[i] = gc[i]; tmo[i] = 1'b1;
                end else if (!lk && held[i] < 255) begin
                    held[i]++;
                end
            end else if (waitc[i] > 0) begin
                waitc[i]--;
            end else if (r != 16'h0) begin
                for (int k = 1; k <= 16; k++) begin
                    int c;
                    c = (last[i] + k) % 16;
                    if (owner[i] < 0 && r[c]) begin
                        owner[i] = c; held[i] = 1; sidx[i] = c;
                    end
                end
            end
        end
    endtask

    function automatic logic [23:0] expected(input int i);
        logic [15:0] g;
        if (owner[i] >= 0) begin
            g = 16'hFFFF;
            g[owner[i]] = 1'b0;
            return {4'(sidx[i]), 1'b1, 1'b0, g, 1'b1, tmo[i]};
        end
        return {4'(sidx[i]), 1'b0, 1'b1, 16'hFFFF, 1'b0, tmo[i]};
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d", i),
                  {sel_idx[i], sel_e1[i], sel_e2[i], gnt_n[i], busy[i], timeout[i]},
                  expected(i));
    endtask

    task automatic tick();
        logic lk;
`ifdef DECODE_ARB_LOCK_EN
        lk = lock_v;
`else
        lk = 1'b0;
`endif
        @(posedge clk);
        model_step(req, lk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        hm[0] = HM0; hm[1] = HM1; hm[2] = HM2;
        gc[0] = GC0; gc[1] = GC1; gc[2] = GC2;
        model_reset();
        @(negedge clk);
        #1;
        check_all();
        check("reset_dut0", {sel_idx[0], sel_e1[0], sel_e2[0], gnt_n[0], busy[0], timeout[0]},
              {4'h0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, then drop.
        req = 16'h0001; ticks(4);
        req = 16'h0000; ticks(4);

        // Two constant requesters: hold limit and alternation.
        req = 16'h8001; ticks(40);
        req = 16'h0000; ticks(4);

        // Everyone requesting; dut0's owner drops out after two grant cycles.
        do_reset();
        for (int t = 0; t < 80; t++) begin
            req = 16'hFFFF;
            if (owner[0] >= 0 && held[0] >= 2) req[owner[0]] = 1'b0;
            tick();
        end
        req = 16'h0000; ticks(4);

        // Asynchronous reset in the middle of a grant.
        req = 16'h0001; ticks(3);
        do_reset();
        req = 16'h0010; ticks(5);
        req = 16'h0000; ticks(4);

        // Release with another requester waiting.
        do_reset();
        req = 16'h0088; ticks(3);
        req = 16'h0080; ticks(6);
        req = 16'h0000; ticks(4);

        // Lock held across the whole grant.
        lock_v = 1'b1;
        req = 16'h0020; ticks(10);
        req = 16'h0000; ticks(4);
        lock_v = 1'b0;

        // Random requests with sticky levels.
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < 16; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 15) == 0) lock_v = ~lock_v;
            if ($urandom_range(0, 400) == 0) do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
